// File: rtl/flush_nibble_drain_if.sv
// Flush-word input and nibble-stream output of the flush nibble drain.
// The master modport belongs to the word source and nibble sink; the slave modport belongs to the drain itself.
interface flush_nibble_drain_if;
   logic        flush_word_valid_i;
   logic [31:0] flush_word_i;
   logic        flush_word_ready_o;
   logic        nib_valid_o;
   logic [3:0]  nib_data_o;
   logic        nib_last_o;
   logic        nib_ready_i;

   modport master (
      output flush_word_valid_i,
      output flush_word_i,
      output nib_ready_i,
      input  flush_word_ready_o,
      input  nib_valid_o,
      input  nib_data_o,
      input  nib_last_o
   );

   modport slave (
      input  flush_word_valid_i,
      input  flush_word_i,
      input  nib_ready_i,
      output flush_word_ready_o,
      output nib_valid_o,
      output nib_data_o,
      output nib_last_o
   );
endinterface

// File: rtl/flush_nibble_drain.sv
// Flush nibble drain. It takes 32-bit flush words, strips the trailing pad
// nibbles, and replays the remaining nibbles one per cycle with a last marker.
// A word made only of pad nibbles is dropped and counted.
module flush_nibble_drain #(
   parameter logic [3:0] PAD   = 4'hC,
   parameter int         CNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   flush_nibble_drain_if.slave bus,
   output logic [CNT_W-1:0]    word_cnt_o,
   output logic [CNT_W-1:0]    drop_cnt_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      word_q, word_d;
   logic [3:0]       len_q, len_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic [3:0]       in_len;
   logic             nib_valid;
   logic [3:0]       nib_data;
   logic             nib_last;
   logic             word_ready;
   logic             accept;

   // Compute the real length of the incoming word: one plus the position of the highest non-pad nibble
   always_comb begin
      in_len = 4'd0;
      for (int k = 0; k < 8; k++) begin
         if (bus.flush_word_i[4*k +: 4] != PAD) begin
            in_len = 4'(k + 1);
         end
      end
   end

   // Drive the nibble stream from the held word, and take a new word when idle or on the final nibble's handshake
   always_comb begin
      nib_valid = (state_q == DRAIN);
      nib_data  = 4'd0;
      nib_last  = 1'b0;
      if (nib_valid) begin
         nib_data = word_q[{idx_q, 2'b00} +: 4];
         nib_last = ({1'b0, idx_q} == (len_q - 4'd1));
      end
      word_ready = (state_q == IDLE) | (nib_valid & bus.nib_ready_i & nib_last);
      accept     = bus.flush_word_valid_i & word_ready;
   end

   // Next-state logic: step through the held word, then load a new word or drop an all-pad word
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      len_d      = len_q;
      idx_d      = idx_q;
      word_cnt_d = word_cnt_q;
      drop_cnt_d = drop_cnt_q;

      if (nib_valid && bus.nib_ready_i) begin
         if (nib_last) begin
            state_d = IDLE;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end

      if (accept) begin
         if (in_len != 4'd0) begin
            word_d     = bus.flush_word_i;
            len_d      = in_len;
            idx_d      = 3'd0;
            state_d    = DRAIN;
            word_cnt_d = word_cnt_q + CNT_W'(1);
         end else begin
            state_d = IDLE;
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
               drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // State and held-word registers; reset discards any partially drained word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         word_q     <= 32'd0;
         len_q      <= 4'd0;
         idx_q      <= 3'd0;
         word_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         word_cnt_q <= word_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.flush_word_ready_o = word_ready;
   assign bus.nib_valid_o        = nib_valid;
   assign bus.nib_data_o         = nib_data;
   assign bus.nib_last_o         = nib_last;
   assign word_cnt_o             = word_cnt_q;
   assign drop_cnt_o             = drop_cnt_q;

endmodule

// File: tb/tb_flush_nibble_drain.sv
// Testbench for flush_nibble_drain. It runs fixed vector tables, hand-written
// corner sequences, and random traffic against a queue-based reference model.
module tb_flush_nibble_drain;

   localparam logic [3:0] PAD = 4'hC;

   logic       clk;
   logic       reset;
   logic [7:0] word_cnt;
   logic [7:0] drop_cnt;

   flush_nibble_drain_if bus ();

   flush_nibble_drain #(
      .PAD   (PAD),
      .CNT_W (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .word_cnt_o (word_cnt),
      .drop_cnt_o (drop_cnt)
   );

   // Free-running clock with a 10-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        v;
      logic [31:0] w;
      logic        r;
      logic        ev;
      logic [3:0]  ed;
      logic        el;
      logic        er;
   } vec_t;

   vec_t vecs[$];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the nibbles still owed to the sink ({last, data}), plus the two counters
   logic [4:0]  mq[$];
   int          m_word;
   int          m_drop;

   logic        cur_v;
   logic [31:0] cur_w;
   logic        cur_r;

   function automatic int realLen(input logic [31:0] w);
      int len;
      len = 8;
      while (len > 0 && w[4*(len-1) +: 4] == PAD) len--;
      return len;
   endfunction

   function void addVec(input logic v, input logic [31:0] w, input logic r,
                        input logic ev, input logic [3:0] ed, input logic el, input logic er);
      vec_t t;
      t.v = v; t.w = w; t.r = r; t.ev = ev; t.ed = ed; t.el = el; t.er = er;
      vecs.push_back(t);
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] w, input logic r);
      cur_v = v; cur_w = w; cur_r = r;
      bus.flush_word_valid_i = v;
      bus.flush_word_i       = w;
      bus.nib_ready_i        = r;
      @(negedge clk);
   endtask

   function automatic logic modelReady();
      return (mq.size() == 0) || (cur_r && mq[0][4]);
   endfunction

   task automatic checkOutput();
      logic       ev;
      logic [3:0] ed;
      logic       el;
      ev = (mq.size() != 0);
      ed = ev ? mq[0][3:0] : 4'd0;
      el = ev ? mq[0][4]   : 1'b0;
      checkValue("ready",    {31'd0, bus.flush_word_ready_o}, {31'd0, modelReady()});
      checkValue("valid",    {31'd0, bus.nib_valid_o},        {31'd0, ev});
      checkValue("data",     {28'd0, bus.nib_data_o},         {28'd0, ed});
      checkValue("last",     {31'd0, bus.nib_last_o},         {31'd0, el});
      checkValue("word_cnt", {24'd0, word_cnt},               m_word % 256);
      checkValue("drop_cnt", {24'd0, drop_cnt},               m_drop);
   endtask

   task automatic advanceCycle();
      logic acc;
      int   len;
      acc = cur_v && modelReady();
      if (mq.size() != 0 && cur_r) void'(mq.pop_front());
      if (acc) begin
         len = realLen(cur_w);
         if (len == 0) begin
            if (m_drop < 255) m_drop++;
         end else begin
            for (int k = 0; k < len; k++) mq.push_back({(k == len - 1), cur_w[4*k +: 4]});
            m_word++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic runCycle(input logic v, input logic [31:0] w, input logic r);
      applyStimulus(v, w, r);
      checkOutput();
      advanceCycle();
   endtask

   task automatic runTable(input string tag);
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].v, vecs[i].w, vecs[i].r);
         checkOutput();
         checkValue({tag, "_tab_valid"}, {31'd0, bus.nib_valid_o},        {31'd0, vecs[i].ev});
         checkValue({tag, "_tab_data"},  {28'd0, bus.nib_data_o},         {28'd0, vecs[i].ed});
         checkValue({tag, "_tab_last"},  {31'd0, bus.nib_last_o},         {31'd0, vecs[i].el});
         checkValue({tag, "_tab_ready"}, {31'd0, bus.flush_word_ready_o}, {31'd0, vecs[i].er});
         advanceCycle();
      end
      vecs.delete();
   endtask

   task automatic doReset();
      bus.flush_word_valid_i = 1'b0;
      bus.flush_word_i       = 32'd0;
      bus.nib_ready_i        = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      checkValue("rst_ready",    {31'd0, bus.flush_word_ready_o}, 32'd1);
      checkValue("rst_valid",    {31'd0, bus.nib_valid_o},        32'd0);
      checkValue("rst_data",     {28'd0, bus.nib_data_o},         32'd0);
      checkValue("rst_last",     {31'd0, bus.nib_last_o},         32'd0);
      checkValue("rst_word_cnt", {24'd0, word_cnt},               32'd0);
      checkValue("rst_drop_cnt", {24'd0, drop_cnt},               32'd0);
      mq.delete();
      m_word = 0;
      m_drop = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Main test sequence
   initial begin
      logic [31:0] w;
      int          len;
      reset = 1'b0;
      bus.flush_word_valid_i = 1'b0;
      bus.flush_word_i       = 32'd0;
      bus.nib_ready_i        = 1'b0;
      m_word = 0;
      m_drop = 0;
      @(posedge clk);
      #1;

      // Short word with a pad tail
      doReset();
      addVec(1, 32'hCCCCC321, 1, 0, 4'h0, 0, 1);
      addVec(0, 32'h0,        1, 1, 4'h1, 0, 0);
      addVec(0, 32'h0,        1, 1, 4'h2, 0, 0);
      addVec(0, 32'h0,        1, 1, 4'h3, 1, 1);
      addVec(0, 32'h0,        1, 0, 4'h0, 0, 1);
      runTable("short");
      checkValue("short_word_cnt", {24'd0, word_cnt}, 32'd1);

      // Two full-length words back to back with no bubble
      doReset();
      addVec(1, 32'h87654321, 1, 0, 4'h0, 0, 1);
      for (int k = 1; k <= 7; k++) addVec(1, 32'h0000000A, 1, 1, 4'(k), 0, 0);
      addVec(1, 32'h0000000A, 1, 1, 4'h8, 1, 1);
      addVec(0, 32'h0, 1, 1, 4'hA, 0, 0);
      for (int k = 0; k < 6; k++) addVec(0, 32'h0, 1, 1, 4'h0, 0, 0);
      addVec(0, 32'h0, 1, 1, 4'h0, 1, 1);
      addVec(0, 32'h0, 1, 0, 4'h0, 0, 1);
      runTable("b2b");
      checkValue("b2b_word_cnt", {24'd0, word_cnt}, 32'd2);

      // Sink backpressure; an embedded pad nibble is real data
      doReset();
      addVec(1, 32'hCCCC3C21, 1, 0, 4'h0, 0, 1);
      addVec(0, 32'h0, 1, 1, 4'h1, 0, 0);
      addVec(0, 32'h0, 0, 1, 4'h2, 0, 0);
      addVec(0, 32'h0, 0, 1, 4'h2, 0, 0);
      addVec(0, 32'h0, 1, 1, 4'h2, 0, 0);
      addVec(0, 32'h0, 0, 1, 4'hC, 0, 0);
      addVec(0, 32'h0, 0, 1, 4'hC, 0, 0);
      addVec(0, 32'h0, 1, 1, 4'hC, 0, 0);
      addVec(0, 32'h0, 0, 1, 4'h3, 1, 0);
      addVec(0, 32'h0, 0, 1, 4'h3, 1, 0);
      addVec(0, 32'h0, 1, 1, 4'h3, 1, 1);
      addVec(0, 32'h0, 1, 0, 4'h0, 0, 1);
      runTable("stall");

      // All-pad words are dropped and the drop counter saturates
      doReset();
      for (int i = 0; i < 300; i++) runCycle(1'b1, 32'hCCCCCCCC, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkValue("drop_sat",      {24'd0, drop_cnt},               32'd255);
      checkValue("drop_no_word",  {24'd0, word_cnt},               32'd0);
      checkValue("drop_no_valid", {31'd0, bus.nib_valid_o},        32'd0);
      checkValue("drop_ready",    {31'd0, bus.flush_word_ready_o}, 32'd1);
      advanceCycle();

      // Asynchronous reset in the middle of a drain
      doReset();
      runCycle(1'b1, 32'h87654321, 1'b1);
      runCycle(1'b0, 32'h0, 1'b1);
      runCycle(1'b0, 32'h0, 1'b1);
      runCycle(1'b0, 32'h0, 1'b1);
      checkValue("mid_nib4", {28'd0, bus.nib_data_o}, 32'd4);
      reset = 1'b0;
      #2;
      checkValue("mid_rst_valid", {31'd0, bus.nib_valid_o},        32'd0);
      checkValue("mid_rst_ready", {31'd0, bus.flush_word_ready_o}, 32'd1);
      checkValue("mid_rst_wcnt",  {24'd0, word_cnt},               32'd0);
      checkValue("mid_rst_dcnt",  {24'd0, drop_cnt},               32'd0);
      mq.delete();
      m_word = 0;
      m_drop = 0;
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      runCycle(1'b1, 32'hCCCCCCC5, 1'b1);
      checkValue("post_valid", {31'd0, bus.nib_valid_o}, 32'd1);
      checkValue("post_data",  {28'd0, bus.nib_data_o},  32'd5);
      checkValue("post_last",  {31'd0, bus.nib_last_o},  32'd1);
      runCycle(1'b0, 32'h0, 1'b1);
      runCycle(1'b0, 32'h0, 1'b1);

      // Random traffic against the reference model
      doReset();
      for (int i = 0; i < 1500; i++) begin
         w   = $urandom;
         len = $urandom_range(0, 8);
         for (int k = len; k < 8; k++) w[4*k +: 4] = PAD;
         runCycle(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
